event_logger: RTL and testbench
===============================

// Module: event_logger
// PURPOSE
//  Capture buffer downstream of the monitor. Each flagged event stores one entry: driven
//  operands, DUT result and data-counter index. A host or debug port drains entries over
//  a valid/ready handshake, so failures can be inspected alongside the scoreboard totals.
// PARAMETERS
//  WIDTH         16  width of operands and DUT result
//  DEPTH_LOG2    4   log2 of buffer entries (default 16)
//  STOP_ON_FULL  1   1: when full, drop new events; 0: when full, overwrite the oldest entry
// PORTS
//  clk_dut     in   1           single clock, all logic on posedge
//  reset       in   1           synchronous, active-high
//  i_freeze    in   1           1 = ignore i_event (no capture); reads still allowed
//  i_event     in   1           monitor event strobe, one capture per high cycle
//  i_dut_ia    in   WIDTH       operand a aligned to i_event
//  i_dut_ib    in   WIDTH       operand b aligned to i_event
//  i_dut_os    in   WIDTH       DUT result aligned to i_event
//  i_data_idx  in   32          scoreboard data counter value at the event
//  i_rd_ready  in   1           consumer accepts head entry when o_rd_valid=1
//  o_rd_valid  out  1           buffer non-empty; head entry on o_rd_* is valid
//  o_rd_a      out  WIDTH       head entry operand a
//  o_rd_b      out  WIDTH       head entry operand b
//  o_rd_os     out  WIDTH       head entry DUT result
//  o_rd_idx    out  32          head entry data index
//  o_count     out  DEPTH_LOG2+1  entries currently held, 0..2^DEPTH_LOG2
//  o_full      out  1           o_count == 2^DEPTH_LOG2
//  o_drop_ctr  out  32          events lost (dropped or overwritten), saturates at 32'hFFFFFFFF
// BEHAVIOUR
//  - Reset: wr_ptr=rd_ptr=0, o_count=0, o_full=0, o_rd_valid=0, o_drop_ctr=0.
//    o_rd_* data is don't-care while o_rd_valid=0. Reset wins over all other activity,
//    including reset asserted mid-burst; the storage array itself is not cleared.
//  - Write: wr = i_event & ~i_freeze, sampled at posedge. The entry {ia,ib,os,idx} is
//    stored at wr_ptr and wr_ptr increments modulo 2^DEPTH_LOG2.
//  - Read: pop = o_rd_valid & i_rd_ready. rd_ptr increments modulo 2^DEPTH_LOG2.
//    i_rd_ready while empty has no effect.
//  - Head output: o_rd_* = mem[rd_ptr]; o_rd_valid = (o_count != 0). All are registered
//    state.
//  - Latency: an event captured at edge N into an empty buffer gives o_rd_valid=1 after
//    edge N. No same-cycle bypass.
//  - Not full: wr & pop together -> both performed, count unchanged. wr alone -> count+1.
//    pop alone -> count-1.
//  - Full, STOP_ON_FULL=1:
//      wr & ~pop -> entry discarded, drop_ctr+1.
//      wr & pop  -> both performed, count stays full, no drop.
//  - Full, STOP_ON_FULL=0:
//      wr & ~pop -> oldest entry overwritten; wr_ptr and rd_ptr both advance; count stays
//                   full; drop_ctr+1.
//      wr & pop  -> same as not-full case, no drop.
//  - Pointer wrap: entries stay strictly in arrival order across wrap.
//  - drop_ctr: saturates at 32'hFFFFFFFF and never wraps.
//  - Freeze: blocks capture only. A frozen event is not counted as dropped.
// TESTING
//  1. Reset, then one event (ia=3, ib=5, os=8, idx=7) -> next cycle o_rd_valid=1,
//     o_rd_a=3, o_rd_os=8, o_rd_idx=7, o_count=1. Pop -> o_rd_valid=0, o_count=0.
//  2. 20 events idx=0..19 with i_rd_ready=0, STOP_ON_FULL=1 -> o_full=1, o_count=16,
//     o_drop_ctr=4. Drain yields idx 0..15 in order.
//  3. Same stimulus with STOP_ON_FULL=0 -> o_drop_ctr=4. Drain yields idx 4..19 in order.
//  4. Full buffer, event and pop in the same cycle -> o_count stays 16, o_drop_ctr
//     unchanged, head advances by one.
//  5. i_freeze=1 during 5 events -> o_count=0, o_drop_ctr=0. Reads of pre-freeze entries
//     still succeed.
//  6. Reset asserted with 9 entries held and a write in flight -> next cycle o_count=0,
//     o_rd_valid=0, o_drop_ctr=0. Capture works normally on the following event.

Source files
------------

// File: rtl/event_logger.sv
// -----------------------------------------------------------------------------
// event_logger
//   Capture buffer that sits downstream of the monitor. Every flagged event
//   stores one entry {operand a, operand b, DUT result, data index}. A host or
//   debug port drains the entries in arrival order over a valid/ready
//   handshake, so failures can be inspected next to the scoreboard totals.
//
// Parameters
//   WIDTH         width of operands and DUT result
//   DEPTH_LOG2    log2 of the number of buffer entries
//   STOP_ON_FULL  1: new events are dropped while full
//                 0: new events overwrite the oldest entry while full
//
// Ports
//   clk_dut     in   single clock, all logic on posedge
//   reset       in   synchronous, active-high
//   i_freeze    in   1 = ignore i_event (reads still allowed)
//   i_event     in   capture strobe, one entry per high cycle
//   i_dut_ia    in   operand a aligned to i_event
//   i_dut_ib    in   operand b aligned to i_event
//   i_dut_os    in   DUT result aligned to i_event
//   i_data_idx  in   scoreboard data counter at the event
//   i_rd_ready  in   consumer accepts the head entry when o_rd_valid=1
//   o_rd_valid  out  buffer non-empty, head entry valid
//   o_rd_a/b/os/idx out head entry fields (don't-care while o_rd_valid=0)
//   o_count     out  entries held, 0..2^DEPTH_LOG2
//   o_full      out  o_count == 2^DEPTH_LOG2
//   o_drop_ctr  out  events lost (dropped or overwritten), saturating
// -----------------------------------------------------------------------------
module event_logger #(
  parameter int WIDTH        = 16,
  parameter int DEPTH_LOG2   = 4,
  parameter bit STOP_ON_FULL = 1'b1
) (
  input  logic                  clk_dut,
  input  logic                  reset,
  input  logic                  i_freeze,
  input  logic                  i_event,
  input  logic [WIDTH-1:0]      i_dut_ia,
  input  logic [WIDTH-1:0]      i_dut_ib,
  input  logic [WIDTH-1:0]      i_dut_os,
  input  logic [31:0]           i_data_idx,
  input  logic                  i_rd_ready,
  output logic                  o_rd_valid,
  output logic [WIDTH-1:0]      o_rd_a,
  output logic [WIDTH-1:0]      o_rd_b,
  output logic [WIDTH-1:0]      o_rd_os,
  output logic [31:0]           o_rd_idx,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_full,
  output logic [31:0]           o_drop_ctr
);

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam int                  ENTRY_W  = 3 * WIDTH + 32;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic                STOP     = STOP_ON_FULL;

  // Saturating increment: the loss counter sticks at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Storage and head register carry data only; they are never reset.
  logic [ENTRY_W-1:0]    mem_q [DEPTH];
  logic [ENTRY_W-1:0]    head_q, head_d;
  logic [ENTRY_W-1:0]    wr_entry;

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  valid_q, valid_d;
  logic                  full_q, full_d;
  logic [31:0]           drop_q, drop_d;

  logic                  wr, pop, drop, do_write, adv_rd;

  assign wr_entry = {i_dut_ia, i_dut_ib, i_dut_os, i_data_idx};

  always_comb begin
    wr       = i_event & ~i_freeze;
    pop      = valid_q & i_rd_ready;
    // A write that finds the buffer full with no pop to make room is a loss,
    // either by discarding it or by evicting the oldest entry.
    drop     = wr & full_q & ~pop;
    do_write = wr & ~(drop & STOP);
    adv_rd   = pop | (drop & ~STOP);

    wr_ptr_d = do_write ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = adv_rd   ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    case ({do_write, adv_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    valid_d = (count_d != '0);
    full_d  = (count_d == FULL_CNT);
    drop_d  = drop ? sat_inc(drop_q) : drop_q;

    // The head register holds what mem[rd_ptr] will contain after this edge,
    // so forward the incoming entry when it lands on the new head slot.
    if (do_write && (wr_ptr_q == rd_ptr_d)) begin
      head_d = wr_entry;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_dut) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk_dut) begin
    if (do_write && !reset) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
    head_q <= head_d;
  end

  assign o_rd_valid = valid_q;
  assign o_rd_a     = head_q[32 + 2*WIDTH +: WIDTH];
  assign o_rd_b     = head_q[32 + WIDTH   +: WIDTH];
  assign o_rd_os    = head_q[32           +: WIDTH];
  assign o_rd_idx   = head_q[31:0];
  assign o_count    = count_q;
  assign o_full     = full_q;
  assign o_drop_ctr = drop_q;

endmodule

// File: tb/tb_event_logger.sv
module tb_event_logger;

  logic        clk_dut = 1'b0;
  logic        reset;
  logic        i_freeze;
  logic        i_event;
  logic [15:0] i_dut_ia, i_dut_ib, i_dut_os;
  logic [31:0] i_data_idx;
  logic        i_rd_ready;

  // Drop-on-full instance
  logic        s_valid, s_full;
  logic [15:0] s_a, s_b, s_os;
  logic [31:0] s_idx, s_drop;
  logic [4:0]  s_count;
  // Overwrite-oldest instance
  logic        w_valid, w_full;
  logic [15:0] w_a, w_b, w_os;
  logic [31:0] w_idx, w_drop;
  logic [4:0]  w_count;

  int errors = 0;
  int checks = 0;

  always #5 clk_dut = ~clk_dut;

  event_logger #(.WIDTH(16), .DEPTH_LOG2(4), .STOP_ON_FULL(1'b1)) u_stop (
    .clk_dut(clk_dut), .reset(reset), .i_freeze(i_freeze), .i_event(i_event),
    .i_dut_ia(i_dut_ia), .i_dut_ib(i_dut_ib), .i_dut_os(i_dut_os),
    .i_data_idx(i_data_idx), .i_rd_ready(i_rd_ready),
    .o_rd_valid(s_valid), .o_rd_a(s_a), .o_rd_b(s_b), .o_rd_os(s_os),
    .o_rd_idx(s_idx), .o_count(s_count), .o_full(s_full), .o_drop_ctr(s_drop)
  );

  event_logger #(.WIDTH(16), .DEPTH_LOG2(4), .STOP_ON_FULL(1'b0)) u_ovw (
    .clk_dut(clk_dut), .reset(reset), .i_freeze(i_freeze), .i_event(i_event),
    .i_dut_ia(i_dut_ia), .i_dut_ib(i_dut_ib), .i_dut_os(i_dut_os),
    .i_data_idx(i_data_idx), .i_rd_ready(i_rd_ready),
    .o_rd_valid(w_valid), .o_rd_a(w_a), .o_rd_b(w_b), .o_rd_os(w_os),
    .o_rd_idx(w_idx), .o_count(w_count), .o_full(w_full), .o_drop_ctr(w_drop)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_dut);
    #1;
  endtask

  task automatic set_event(input logic [31:0] idx);
    i_event    = 1'b1;
    i_data_idx = idx;
    i_dut_ia   = 16'(idx + 32'd100);
    i_dut_ib   = 16'(idx + 32'd200);
    i_dut_os   = 16'(idx + 32'd300);
  endtask

  initial begin
    reset = 1'b1; i_freeze = 1'b0; i_event = 1'b0; i_rd_ready = 1'b0;
    i_dut_ia = '0; i_dut_ib = '0; i_dut_os = '0; i_data_idx = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_valid", {63'd0, s_valid}, 64'd0);
    chk("rst_count", {59'd0, s_count}, 64'd0);
    chk("rst_full",  {63'd0, s_full},  64'd0);
    chk("rst_drop",  {32'd0, s_drop},  64'd0);
    chk("rst_valid_ovw", {63'd0, w_valid}, 64'd0);

    // Single event, visible the cycle after capture
    i_event = 1'b1; i_dut_ia = 16'd3; i_dut_ib = 16'd5; i_dut_os = 16'd8; i_data_idx = 32'd7;
    tick();
    i_event = 1'b0;
    chk("t1_valid", {63'd0, s_valid}, 64'd1);
    chk("t1_a",     {48'd0, s_a},     64'd3);
    chk("t1_b",     {48'd0, s_b},     64'd5);
    chk("t1_os",    {48'd0, s_os},    64'd8);
    chk("t1_idx",   {32'd0, s_idx},   64'd7);
    chk("t1_count", {59'd0, s_count}, 64'd1);
    i_rd_ready = 1'b1;
    tick();
    chk("t1_pop_valid", {63'd0, s_valid}, 64'd0);
    chk("t1_pop_count", {59'd0, s_count}, 64'd0);
    // Ready while empty has no effect
    tick();
    i_rd_ready = 1'b0;
    chk("t1_empty_rd_count", {59'd0, s_count}, 64'd0);
    chk("t1_empty_rd_drop",  {32'd0, s_drop},  64'd0);

    // 20 events with no reads: both flavours lose 4
    for (int i = 0; i < 20; i++) begin
      set_event(32'(i));
      tick();
    end
    i_event = 1'b0;
    chk("t2_full",  {63'd0, s_full},  64'd1);
    chk("t2_count", {59'd0, s_count}, 64'd16);
    chk("t2_drop",  {32'd0, s_drop},  64'd4);
    chk("t2_head",  {32'd0, s_idx},   64'd0);
    chk("t3_full",  {63'd0, w_full},  64'd1);
    chk("t3_count", {59'd0, w_count}, 64'd16);
    chk("t3_drop",  {32'd0, w_drop},  64'd4);
    chk("t3_head",  {32'd0, w_idx},   64'd4);

    // Full: event and pop together keep count, no loss, head advances
    set_event(32'd100);
    i_rd_ready = 1'b1;
    tick();
    i_event = 1'b0;
    chk("t4_count_stop", {59'd0, s_count}, 64'd16);
    chk("t4_drop_stop",  {32'd0, s_drop},  64'd4);
    chk("t4_head_stop",  {32'd0, s_idx},   64'd1);
    chk("t4_count_ovw",  {59'd0, w_count}, 64'd16);
    chk("t4_drop_ovw",   {32'd0, w_drop},  64'd4);
    chk("t4_head_ovw",   {32'd0, w_idx},   64'd5);

    // Drain: stop holds 1..15,100 ; overwrite holds 5..19,100
    for (int k = 0; k < 16; k++) begin
      chk("drain_stop_idx", {32'd0, s_idx}, (k < 15) ? 64'(k + 1) : 64'd100);
      chk("drain_ovw_idx",  {32'd0, w_idx}, (k < 15) ? 64'(k + 5) : 64'd100);
      chk("drain_stop_a",   {48'd0, s_a},   (k < 15) ? 64'(k + 101) : 64'd200);
      tick();
    end
    i_rd_ready = 1'b0;
    chk("drain_valid", {63'd0, s_valid}, 64'd0);
    chk("drain_count", {59'd0, s_count}, 64'd0);
    chk("drain_full",  {63'd0, s_full},  64'd0);

    // Freeze blocks capture only, frozen events are not losses
    set_event(32'd50); tick();
    set_event(32'd51); tick();
    i_freeze = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_event(32'(60 + i));
      tick();
    end
    i_event = 1'b0;
    chk("t5_count", {59'd0, s_count}, 64'd2);
    chk("t5_drop",  {32'd0, s_drop},  64'd4);
    chk("t5_head",  {32'd0, s_idx},   64'd50);
    i_rd_ready = 1'b1;
    tick();
    chk("t5_rd2",   {32'd0, s_idx},   64'd51);
    chk("t5_os2",   {48'd0, s_os},    64'd351);
    tick();
    i_rd_ready = 1'b0;
    i_freeze = 1'b0;
    chk("t5_empty", {59'd0, s_count}, 64'd0);

    // Reset with 9 entries held and a write in flight
    for (int i = 0; i < 9; i++) begin
      set_event(32'(200 + i));
      tick();
    end
    chk("t6_pre_count", {59'd0, s_count}, 64'd9);
    set_event(32'd209);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    i_event = 1'b0;
    chk("t6_count", {59'd0, s_count}, 64'd0);
    chk("t6_valid", {63'd0, s_valid}, 64'd0);
    chk("t6_drop",  {32'd0, s_drop},  64'd0);
    chk("t6_drop_ovw", {32'd0, w_drop}, 64'd0);
    tick();
    chk("t6_idle_count", {59'd0, s_count}, 64'd0);
    i_event = 1'b1; i_dut_ia = 16'd11; i_dut_ib = 16'd22; i_dut_os = 16'd33; i_data_idx = 32'd300;
    tick();
    i_event = 1'b0;
    chk("t6_cap_valid", {63'd0, s_valid}, 64'd1);
    chk("t6_cap_idx",   {32'd0, s_idx},   64'd300);
    chk("t6_cap_a",     {48'd0, s_a},     64'd11);
    chk("t6_cap_count", {59'd0, s_count}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
